cu_inst_scheduler: RTL and testbench

CU_INST_SCHEDULER -- requirements
Module: cu_inst_scheduler

---
 rtl/cu_inst_scheduler.sv | 75 +++++++
 tb/tb_cu_inst_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cu_inst_scheduler.sv
// cu_inst_scheduler: filters filter/ifmap packets toward the control unit and gates each timestep on PE acks
// Ports: in_valid/in_ready/in_data packet source; out_valid/out_ready/out_data one-register forward stage;
// pe_mask selects required acks; ifmap_per_ts sets ifmaps per timestep (0 means 1);
// cur_timestep expected ts bit; ts_done/err_seq/err_ts single-cycle status pulses.
module cu_inst_scheduler #(
  parameter int INST_WIDTH  = 45,
  parameter int NUM_PE      = 16,
  parameter int PE_ID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_data,
  input  logic [NUM_PE-1:0]     pe_mask,
  input  logic [7:0]            ifmap_per_ts,
  output logic                  cur_timestep,
  output logic                  ts_done,
  output logic                  err_seq,
  output logic                  err_ts
);
  typedef enum logic [1:0] {NO_FILTER, ISSUE, WAIT_ACK} state_t;
  state_t state;
  logic [NUM_PE-1:0] ack_vec, ack_hit;
  logic [7:0] ifmap_cnt, ifmap_max;
  logic is_ack, is_filter, is_ifmap, ts_match, out_free, complete, accept, fwd, ifmap_step, last;
  assign is_ack     = ~in_data[0];
  assign is_filter  = in_data[0] & in_data[1];
  assign is_ifmap   = in_data[0] & ~in_data[1];
  assign ts_match   = in_data[2] == cur_timestep;
  assign out_free   = ~out_valid | out_ready;
  assign complete   = (state == WAIT_ACK) & (&(ack_vec | ~pe_mask));
  assign in_ready   = rst_n & (is_ack | ((state != WAIT_ACK) &
                      (is_filter ? out_free : ((state == NO_FILTER) | ~ts_match | out_free))));
  assign accept     = in_valid & in_ready;
  assign fwd        = accept & (is_filter | (is_ifmap & (state == ISSUE) & ts_match));
  assign ifmap_step = fwd & is_ifmap;
  assign ifmap_max  = (ifmap_per_ts == 8'd0) ? 8'd1 : ifmap_per_ts;
  // compare in 9 bits so a count of 255 cannot wrap past the target
  assign last       = ({1'b0, ifmap_cnt} + 9'd1) >= {1'b0, ifmap_max};
  // out-of-range PE ids match no bit and are ignored
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_PE; i++)
      ack_hit[i] = int'(in_data[PE_ID_WIDTH:1]) == i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= NO_FILTER;
      out_valid    <= 1'b0;
      out_data     <= '0;
      ack_vec      <= '0;
      ifmap_cnt    <= '0;
      cur_timestep <= 1'b0;
      ts_done      <= 1'b0;
      err_seq      <= 1'b0;
      err_ts       <= 1'b0;
    end else begin
      ts_done      <= complete;
      err_seq      <= accept & is_ifmap & (state == NO_FILTER);
      err_ts       <= accept & is_ifmap & (state == ISSUE) & ~ts_match;
      out_valid    <= fwd | (out_valid & ~out_ready);
      out_data     <= fwd ? in_data : out_data;
      // clearing on completion wins over an ack landing in the same cycle
      ack_vec      <= complete ? '0 : ack_vec | ((accept & is_ack) ? ack_hit : '0);
      cur_timestep <= cur_timestep ^ complete;
      ifmap_cnt    <= ifmap_step ? (last ? 8'd0 : ifmap_cnt + 8'd1) : ifmap_cnt;
      state        <= (complete | (fwd & is_filter)) ? ISSUE :
                      (ifmap_step & last) ? WAIT_ACK : state;
    end
  end
endmodule

// File: tb/tb_cu_inst_scheduler.sv
// tb_cu_inst_scheduler: directed self-checking bench for cu_inst_scheduler
module tb_cu_inst_scheduler;
  localparam int W = 45;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] in_data = '0, out_data;
  logic [15:0] pe_mask = 16'h0003;
  logic [7:0] ifmap_per_ts = 8'd2;
  logic cur_timestep, ts_done, err_seq, err_ts;
  int tests = 0, fails = 0;
  cu_inst_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .pe_mask(pe_mask),
    .ifmap_per_ts(ifmap_per_ts), .cur_timestep(cur_timestep), .ts_done(ts_done),
    .err_seq(err_seq), .err_ts(err_ts)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ack(input int pe);
    return W'(pe) << 1;
  endfunction
  function automatic logic [W-1:0] filt(input int p);
    return (W'(p) << 3) | W'(3);
  endfunction
  function automatic logic [W-1:0] ifm(input int p, input bit ts);
    return (W'(p) << 3) | (W'(ts) << 2) | W'(1);
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    #1;
  endtask
  initial begin
    drive(ack(0));
    chk("rdy_in_reset", in_ready, 0);
    cyc(); cyc();
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ts", cur_timestep, 0);
    chk("rst_pulses", {ts_done, err_seq, err_ts}, 0);
    rst_n = 1'b1;
    cyc();
    drive(ifm(1, 0));
    chk("nf_ifmap_rdy", in_ready, 1);
    cyc(); in_valid = 1'b0;
    chk("err_seq_pulse", err_seq, 1);
    chk("err_seq_no_fwd", out_valid, 0);
    cyc();
    chk("err_seq_clear", err_seq, 0);
    drive(filt('hA));
    chk("filt_rdy", in_ready, 1);
    cyc();
    chk("filt_fwd_v", out_valid, 1);
    chk("filt_fwd_d", out_data, filt('hA));
    drive(ifm('hB, 0));
    chk("ifmA_rdy", in_ready, 1);
    cyc();
    chk("ifmA_fwd", out_data, ifm('hB, 0));
    drive(ifm('hC, 0));
    cyc();
    chk("ifmB_fwd", out_data, ifm('hC, 0));
    drive(ifm('hD, 1));
    chk("wait_ifm_stall", in_ready, 0);
    cyc();
    chk("stall_no_fwd", out_valid, 0);
    drive(ack(0));
    chk("ack_rdy_wait", in_ready, 1);
    cyc();
    drive(ack(1));
    cyc();
    drive(ifm('hD, 1));
    chk("complete_cycle_stall", in_ready, 0);
    cyc();
    chk("ts_done_pulse", ts_done, 1);
    chk("ts_toggle1", cur_timestep, 1);
    chk("ifmC_rdy_after", in_ready, 1);
    cyc(); in_valid = 1'b0;
    chk("ifmC_fwd", out_data, ifm('hD, 1));
    chk("ifmC_v", out_valid, 1);
    chk("ts_done_once", ts_done, 0);
    drive(ifm('hE, 0));
    chk("mismatch_rdy", in_ready, 1);
    cyc(); in_valid = 1'b0;
    chk("err_ts_pulse", err_ts, 1);
    chk("err_ts_drop", out_valid, 0);
    drive(ifm('hF, 1));
    cyc(); in_valid = 1'b0;
    chk("cnt_kept_fwd", out_data, ifm('hF, 1));
    chk("err_ts_clear", err_ts, 0);
    drive(filt('h7));
    chk("wait_filt_stall", in_ready, 0);
    drive(ack(0)); cyc();
    drive(ack(0)); cyc();
    drive(ack(5)); cyc();
    chk("dup_no_done", ts_done, 0);
    chk("dup_ts_kept", cur_timestep, 1);
    drive(ack(1)); cyc();
    drive(ack(0));
    chk("ack_rdy_completion", in_ready, 1);
    cyc(); in_valid = 1'b0;
    chk("ack1_done", ts_done, 1);
    chk("ts_toggle2", cur_timestep, 0);
    pe_mask = 16'h0001;
    ifmap_per_ts = 8'd1;
    drive(ifm('h11, 0));
    cyc(); in_valid = 1'b0;
    chk("per1_fwd", out_data, ifm('h11, 0));
    cyc();
    chk("lost_ack_a", ts_done, 0);
    cyc();
    chk("lost_ack_b", ts_done, 0);
    drive(ack(0)); cyc(); in_valid = 1'b0;
    cyc();
    chk("ack_after_loss_done", ts_done, 1);
    chk("ts_toggle3", cur_timestep, 1);
    drive(ack(0)); cyc();
    drive(ifm('h12, 1)); cyc(); in_valid = 1'b0;
    chk("early_ack_fwd", out_data, ifm('h12, 1));
    chk("early_ack_not_yet", ts_done, 0);
    cyc();
    chk("early_ack_done", ts_done, 1);
    chk("ts_toggle4", cur_timestep, 0);
    pe_mask = 16'h0000;
    ifmap_per_ts = 8'd0;
    drive(ifm('h13, 0)); cyc(); in_valid = 1'b0;
    chk("mask0_entry_no_done", ts_done, 0);
    cyc();
    chk("mask0_done", ts_done, 1);
    chk("ts_toggle5", cur_timestep, 1);
    out_ready = 1'b0;
    drive(filt('h20)); cyc();
    chk("hold_v", out_valid, 1);
    drive(filt('h21));
    for (int i = 0; i < 5; i++) begin
      chk("hold_filt_stall", in_ready, 0);
      chk("hold_data", out_data, filt('h20));
      chk("hold_valid", out_valid, 1);
      cyc();
    end
    drive(ack(3));
    chk("hold_ack_rdy", in_ready, 1);
    cyc();
    out_ready = 1'b1;
    drive(filt('h21));
    chk("release_rdy", in_ready, 1);
    cyc(); in_valid = 1'b0;
    out_ready = 1'b0;
    chk("release_fwd", out_data, filt('h21));
    rst_n = 1'b0;
    cyc();
    chk("midrst_v", out_valid, 0);
    chk("midrst_ts", cur_timestep, 0);
    chk("midrst_d", out_data, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(ifm('h30, 0)); cyc(); in_valid = 1'b0;
    chk("midrst_nofilter", err_seq, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
